counter_sequencer: RTL and testbench

Controller that sequences an external enable/clear up-counter (8-bit, synchronous clear, +1 per enabled cycle) to time programmable intervals. It clears the counter, enables it until a latched terminal count is reached, and supports pause, abort and periodic restart. It reports completion with a one-cycle `done` pulse and a completed-interval tally. It sits between the control/register logic and the counter datapath and is the only driver of the counter's enable and clear.

---
 rtl/counter_sequencer.sv | 107 ++++++++++
 tb/tb_counter_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Sequencer for an external 8-bit enable/clear up-counter.
// It times programmable intervals, with pause, abort and periodic restart.
module counter_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             periodic,
   input  logic [WIDTH-1:0] terminal,
   input  logic [WIDTH-1:0] count,
   output logic             cnt_clear,
   output logic             cnt_enable,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] done_count
);

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [WIDTH-1:0] term_r;
   logic             per_r;
   logic [WIDTH-1:0] done_count_r;
   logic [WIDTH-1:0] term_m1_s;

   // The counter already shows term_r-1 in the last RUN cycle; that cycle's increment lands it on term_r.
   assign term_m1_s = term_r - ONE;

   // Next-state selection; stop wins over every other condition outside IDLE.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_next_s = CLEAR;
            else       state_next_s = IDLE;
         end
         CLEAR: begin
            if (stop)                state_next_s = IDLE;
            else if (term_r == ZERO) state_next_s = DONE;
            else                     state_next_s = RUN;
         end
         RUN: begin
            if (stop)                    state_next_s = IDLE;
            else if (count == term_m1_s) state_next_s = DONE;
            else if (pause)              state_next_s = PAUSE;
            else                         state_next_s = RUN;
         end
         PAUSE: begin
            if (stop)        state_next_s = IDLE;
            else if (!pause) state_next_s = RUN;
            else             state_next_s = PAUSE;
         end
         DONE: begin
            if (stop)       state_next_s = IDLE;
            else if (per_r) state_next_s = CLEAR;
            else            state_next_s = IDLE;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State, latched configuration, tally, and output flops that decode the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         term_r       <= ZERO;
         per_r        <= 1'b0;
         done_count_r <= ZERO;
         cnt_clear    <= 1'b0;
         cnt_enable   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_r <= state_next_s;
         if (state_r == IDLE && start) begin
            term_r       <= terminal;
            per_r        <= periodic;
            done_count_r <= ZERO;
         end else if (state_r == DONE) begin
            // A pulse already on the output counts even if stop arrives with it.
            done_count_r <= done_count_r + ONE;
         end else begin
            done_count_r <= done_count_r;
         end
         cnt_clear  <= (state_next_s == CLEAR);
         cnt_enable <= (state_next_s == RUN);
         busy       <= (state_next_s != IDLE);
         done       <= (state_next_s == DONE);
      end
   end

   assign done_count = done_count_r;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: models the external counter and checks every cycle
// against expected outputs queued at the time each cycle's stimulus is driven.
module tb_counter_sequencer;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             pause = 1'b0;
   logic             periodic = 1'b0;
   logic [WIDTH-1:0] terminal = 8'd0;
   logic [WIDTH-1:0] count = 8'd0;
   logic             cnt_clear;
   logic             cnt_enable;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] done_count;

   typedef struct packed {
      logic [3:0] sid;
      logic       clr;
      logic       en;
      logic       bs;
      logic       dn;
      logic [7:0] dc;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   exp_t last_e = '0;
   int   n_checks = 0;
   int   n_pass = 0;

   counter_sequencer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .periodic   (periodic),
      .terminal   (terminal),
      .count      (count),
      .cnt_clear  (cnt_clear),
      .cnt_enable (cnt_enable),
      .busy       (busy),
      .done       (done),
      .done_count (done_count)
   );

   always #5 clk = ~clk;

   // External counter: synchronous clear, +1 per enabled cycle.
   always @(posedge clk) begin
      if (cnt_clear)       count <= 8'd0;
      else if (cnt_enable) count <= count + 8'd1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Scoreboard consumer: compares one queued expectation per cycle, just after the edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val($sformatf("s%0d_ctl", e.sid), {28'd0, cnt_clear, cnt_enable, busy, done},
                   {28'd0, e.clr, e.en, e.bs, e.dn});
         check_val($sformatf("s%0d_done_count", e.sid), {24'd0, done_count}, {24'd0, e.dc});
         check_val($sformatf("s%0d_count", e.sid), {24'd0, count}, {24'd0, e.cnt});
      end
   end

   // Drive inputs sampled at the coming edge; queue the outputs expected after it.
   // The expected count follows the counter contract applied to the previous expected outputs.
   task automatic cyc(input logic [3:0] sid, input logic rst, input logic st, input logic sp,
                      input logic pa, input logic pe, input logic [7:0] term, input logic [11:0] o);
      exp_t e;
      @(negedge clk);
      reset = rst; start = st; stop = sp; pause = pa; periodic = pe; terminal = term;
      e.sid = sid;
      {e.clr, e.en, e.bs, e.dn, e.dc} = o;
      e.cnt = last_e.clr ? 8'd0 : (last_e.en ? last_e.cnt + 8'd1 : last_e.cnt);
      sb_q.push_back(e);
      last_e = e;
   endtask

   // Expected outputs in cycle n of a one-shot interval started at edge 0, terminal t,
   // with p paused cycles whose pause input is first high in cycle pw.
   function automatic logic [11:0] os(input int n, input int t, input int p, input int pw);
      logic clr, en, bs, dn;
      logic [7:0] dc;
      clr = (n == 1);
      en  = (n >= 2) && (n <= t + 1 + p) && !((p > 0) && (n >= pw + 1) && (n <= pw + p));
      dn  = (n == t + 2 + p);
      bs  = (n >= 1) && (n <= t + 2 + p);
      dc  = (n >= t + 3 + p) ? 8'd1 : 8'd0;
      return {clr, en, bs, dn, dc};
   endfunction

   initial begin
      logic [11:0] o;
      int n;

      cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0);
      cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0);
      cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0);

      // one-shot, terminal 5
      for (int c = 0; c < 10; c++)
         cyc(4'd1, 1'b0, c == 0, 1'b0, 1'b0, 1'b0, 8'd5, os(c + 1, 5, 0, 0));

      // periodic, terminal 3, stop in cycle 12
      for (int c = 0; c < 15; c++) begin
         n = c + 1;
         if (n <= 12) begin
            o[11] = ((n - 1) % 5 == 0);
            o[8]  = (n % 5 == 0);
            o[10] = !o[11] && !o[8];
            o[9]  = 1'b1;
            o[7:0] = 8'((n - 1) / 5);
         end else begin
            o = {4'b0000, 8'd2};
         end
         cyc(4'd2, 1'b0, c == 0, c == 12, 1'b0, c == 0, 8'd3, o);
      end

      // pause in cycles 3-5, terminal 4
      for (int c = 0; c < 13; c++)
         cyc(4'd3, 1'b0, c == 0, 1'b0, (c >= 3) && (c <= 5), 1'b0, 8'd4, os(c + 1, 4, 3, 3));

      // pause raised when count already equals terminal-1: still completes
      for (int c = 0; c < 9; c++)
         cyc(4'd4, 1'b0, c == 0, 1'b0, (c >= 5) && (c <= 7), 1'b0, 8'd4, os(c + 1, 4, 0, 0));

      // terminal 0
      for (int c = 0; c < 5; c++)
         cyc(4'd5, 1'b0, c == 0, 1'b0, 1'b0, 1'b0, 8'd0, os(c + 1, 0, 0, 0));

      // start re-pulsed and terminal/periodic changed while busy
      for (int c = 0; c < 10; c++)
         cyc(4'd6, 1'b0, (c == 0) || (c == 3), 1'b0, 1'b0, c == 3,
             (c == 3) ? 8'd2 : ((c == 4) ? 8'd9 : 8'd5), os(c + 1, 5, 0, 0));

      // reset in RUN, then a fresh one-shot
      for (int c = 0; c < 3; c++)
         cyc(4'd7, 1'b0, c == 0, 1'b0, 1'b0, 1'b0, 8'd5, os(c + 1, 5, 0, 0));
      cyc(4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 12'd0);
      cyc(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 12'd0);
      for (int c = 0; c < 10; c++)
         cyc(4'd8, 1'b0, c == 0, 1'b0, 1'b0, 1'b0, 8'd5, os(c + 1, 5, 0, 0));

      @(posedge clk);
      #3;
      check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
